// File: rtl/mt_thread_sched.sv
// -----------------------------------------------------------------------------
// mt_thread_sched
//
// Round-robin thread scheduler for a barrel-style multithreaded pipeline.
// Each cycle it picks the next ready thread of the current thread group and
// presents its id on tid_read for the register-read stage. The picked id
// travels down a WB_LATENCY-deep writeback pipeline and reappears on
// tid_write when that thread's result is written back.
//
// Threads can be put to sleep for a number of cycles through a per-thread
// block counter. A group switch drains the pipeline, toggles the active
// thread group, wakes all threads and restarts the rotation at thread 0.
//
// Ports
//   clk             clock, all state on rising edge
//   rst             asynchronous reset, active high
//   thread_active   per-thread issue-enable mask for the current group
//   block_valid     load the block counter of block_tid
//   block_tid       thread to block
//   block_cycles    block duration in cycles (0 = no effect)
//   pipe_stall      freeze issue and writeback pipeline
//   grp_switch_req  request a thread-group toggle
//   issue_valid     tid_read is valid
//   tid_read        thread whose registers are read
//   tgrp            current thread group
//   wb_valid        tid_write is valid
//   tid_write       thread whose register is written
//   grp_switch_ack  one-cycle pulse, group toggled
// -----------------------------------------------------------------------------
module mt_thread_sched #(
    parameter int NUM_THREADS  = 8,
    parameter int BITS_THREADS = $clog2(NUM_THREADS),
    parameter int WB_LATENCY   = 3,
    parameter int STALL_BITS   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_THREADS-1:0]  thread_active,
    input  logic                    block_valid,
    input  logic [BITS_THREADS-1:0] block_tid,
    input  logic [STALL_BITS-1:0]   block_cycles,
    input  logic                    pipe_stall,
    input  logic                    grp_switch_req,
    output logic                    issue_valid,
    output logic [BITS_THREADS-1:0] tid_read,
    output logic                    tgrp,
    output logic                    wb_valid,
    output logic [BITS_THREADS-1:0] tid_write,
    output logic                    grp_switch_ack
);

    // Pointer value that makes thread 0 the first candidate of the search.
    localparam logic [BITS_THREADS-1:0] LAST_TID_RST = BITS_THREADS'(NUM_THREADS - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_SWITCH
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                  state_q,        state_d;
    logic                    tgrp_q,         tgrp_d;
    logic                    issue_valid_q,  issue_valid_d;
    logic [BITS_THREADS-1:0] tid_read_q,     tid_read_d;
    logic [BITS_THREADS-1:0] last_tid_q,     last_tid_d;
    logic                    ack_q,          ack_d;
    logic [WB_LATENCY-1:0]   wb_valid_q,     wb_valid_d;
    logic [BITS_THREADS-1:0] wb_tid_q   [WB_LATENCY];
    logic [BITS_THREADS-1:0] wb_tid_d   [WB_LATENCY];
    logic [STALL_BITS-1:0]   block_cnt_q [NUM_THREADS];
    logic [STALL_BITS-1:0]   block_cnt_d [NUM_THREADS];

    // ------------------------------------------------------------------
    // Readiness and round-robin selection
    // ------------------------------------------------------------------
    logic [NUM_THREADS-1:0]  ready;
    logic                    sel_found;
    logic [BITS_THREADS-1:0] sel_tid;
    logic [BITS_THREADS-1:0] cand;

    // Readiness is taken from the counters before the edge, so a thread that
    // is blocked in the same cycle it wins the selection still issues once.
    always_comb begin
        for (int i = 0; i < NUM_THREADS; i++) begin
            ready[i] = thread_active[i] && (block_cnt_q[i] == '0);
        end
    end

    // Search starts one past the last issued thread and wraps, so the last
    // issued thread is the final candidate; a lone ready thread can issue
    // back to back.
    always_comb begin
        sel_found = 1'b0;
        sel_tid   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_THREADS; k++) begin
            cand = BITS_THREADS'((int'(last_tid_q) + k) % NUM_THREADS);
            if (!sel_found && ready[cand]) begin
                sel_found = 1'b1;
                sel_tid   = cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here is given a default first and only
    // blocking assignments are used, so no path leaves a value unassigned
    // and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        tgrp_d        = tgrp_q;
        issue_valid_d = issue_valid_q;
        tid_read_d    = tid_read_q;
        last_tid_d    = last_tid_q;
        ack_d         = 1'b0;
        wb_valid_d    = wb_valid_q;
        for (int s = 0; s < WB_LATENCY; s++) begin
            wb_tid_d[s] = wb_tid_q[s];
        end

        // Block counters run regardless of pipe_stall; a new load wins over
        // the decrement of the same thread.
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (block_valid && (block_cycles != '0) && (block_tid == BITS_THREADS'(i))) begin
                block_cnt_d[i] = block_cycles;
            end else if (block_cnt_q[i] != '0) begin
                block_cnt_d[i] = block_cnt_q[i] - STALL_BITS'(1);
            end else begin
                block_cnt_d[i] = block_cnt_q[i];
            end
        end

        // Writeback pipeline: stage 0 captures the issue register, the last
        // stage drives tid_write. Frozen together with issue on a stall.
        if (!pipe_stall) begin
            wb_valid_d[0] = issue_valid_q;
            wb_tid_d[0]   = tid_read_q;
            for (int s = 1; s < WB_LATENCY; s++) begin
                wb_valid_d[s] = wb_valid_q[s-1];
                wb_tid_d[s]   = wb_tid_q[s-1];
            end
        end

        unique case (state_q)
            ST_RUN: begin
                if (grp_switch_req) begin
                    // Stop issuing on the very edge that accepts the request.
                    state_d = ST_DRAIN;
                    if (!pipe_stall) begin
                        issue_valid_d = 1'b0;
                    end
                end else if (!pipe_stall) begin
                    issue_valid_d = sel_found;
                    if (sel_found) begin
                        tid_read_d = sel_tid;
                        last_tid_d = sel_tid;
                    end
                end
            end

            ST_DRAIN: begin
                if (!pipe_stall) begin
                    issue_valid_d = 1'b0;
                end
                if (!issue_valid_q && (wb_valid_q == '0)) begin
                    state_d = ST_SWITCH;
                end
            end

            ST_SWITCH: begin
                tgrp_d     = ~tgrp_q;
                ack_d      = 1'b1;
                last_tid_d = LAST_TID_RST;
                state_d    = ST_RUN;
                if (!pipe_stall) begin
                    issue_valid_d = 1'b0;
                end
                // The new group starts with every thread awake.
                for (int i = 0; i < NUM_THREADS; i++) begin
                    block_cnt_d[i] = '0;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge inputs regardless of statement order.
    // The counter and writeback arrays are small flop arrays, not RAM, so
    // they are cleared by reset like any other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            tgrp_q        <= 1'b0;
            issue_valid_q <= 1'b0;
            tid_read_q    <= '0;
            last_tid_q    <= LAST_TID_RST;
            ack_q         <= 1'b0;
            wb_valid_q    <= '0;
            for (int s = 0; s < WB_LATENCY; s++) begin
                wb_tid_q[s] <= '0;
            end
            for (int i = 0; i < NUM_THREADS; i++) begin
                block_cnt_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            tgrp_q        <= tgrp_d;
            issue_valid_q <= issue_valid_d;
            tid_read_q    <= tid_read_d;
            last_tid_q    <= last_tid_d;
            ack_q         <= ack_d;
            wb_valid_q    <= wb_valid_d;
            for (int s = 0; s < WB_LATENCY; s++) begin
                wb_tid_q[s] <= wb_tid_d[s];
            end
            for (int i = 0; i < NUM_THREADS; i++) begin
                block_cnt_q[i] <= block_cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign issue_valid    = issue_valid_q;
    assign tid_read       = tid_read_q;
    assign tgrp           = tgrp_q;
    assign wb_valid       = wb_valid_q[WB_LATENCY-1];
    assign tid_write      = wb_tid_q[WB_LATENCY-1];
    assign grp_switch_ack = ack_q;

endmodule

// File: tb/tb_mt_thread_sched.sv
// -----------------------------------------------------------------------------
// tb_mt_thread_sched
//
// Self-checking bench for mt_thread_sched. A cycle-level reference model
// predicts issue, group and ack outputs; predicted issues are queued and
// expected back on tid_write after WB_LATENCY unstalled edges.
// -----------------------------------------------------------------------------
module tb_mt_thread_sched;

    localparam int N   = 8;
    localparam int B   = 3;
    localparam int LAT = 3;
    localparam int SB  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  thread_active;
    logic          block_valid;
    logic [B-1:0]  block_tid;
    logic [SB-1:0] block_cycles;
    logic          pipe_stall;
    logic          grp_switch_req;
    logic          issue_valid;
    logic [B-1:0]  tid_read;
    logic          tgrp;
    logic          wb_valid;
    logic [B-1:0]  tid_write;
    logic          grp_switch_ack;

    mt_thread_sched #(
        .NUM_THREADS (N),
        .BITS_THREADS(B),
        .WB_LATENCY  (LAT),
        .STALL_BITS  (SB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .thread_active (thread_active),
        .block_valid   (block_valid),
        .block_tid     (block_tid),
        .block_cycles  (block_cycles),
        .pipe_stall    (pipe_stall),
        .grp_switch_req(grp_switch_req),
        .issue_valid   (issue_valid),
        .tid_read      (tid_read),
        .tgrp          (tgrp),
        .wb_valid      (wb_valid),
        .tid_write     (tid_write),
        .grp_switch_ack(grp_switch_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        bit iv;
        int tid;
        bit tgrp;
        bit ack;
    } iss_t;

    typedef struct {
        int tid;
        int stamp;
    } wb_t;

    iss_t exp_q[$];
    wb_t  wb_q[$];

    int m_last;
    int m_cnt [N];
    int m_st;        // 0 run, 1 drain, 2 switch
    bit m_iv;
    int m_tid;
    bit m_tgrp;
    bit m_wb_now;
    int m_wb_tid;
    int ne;          // count of unstalled edges

    task automatic model_reset();
        m_last   = N - 1;
        m_st     = 0;
        m_iv     = 0;
        m_tid    = 0;
        m_tgrp   = 0;
        m_wb_now = 0;
        m_wb_tid = 0;
        ne       = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        exp_q.delete();
        wb_q.delete();
    endtask

    // One clock edge: predict, wait, then compare against the DUT.
    task automatic step(input string tag);
        iss_t         e;
        wb_t          w;
        bit           any;
        bit           issued;
        bit           pre_iv;
        bit           stalled;
        int           sel;
        int           idx;
        int           nst;
        logic [B-1:0] etid;

        any = 0; sel = 0; issued = 0;
        pre_iv  = m_iv;
        stalled = pipe_stall;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (!any && thread_active[idx] && m_cnt[idx] == 0) begin
                any = 1;
                sel = idx;
            end
        end

        e.ack = (m_st == 2);
        nst   = m_st;
        case (m_st)
            0: begin
                if (grp_switch_req) begin
                    nst = 1;
                    if (!stalled) m_iv = 0;
                end else if (!stalled) begin
                    m_iv = any;
                    if (any) begin
                        m_tid  = sel;
                        m_last = sel;
                        issued = 1;
                    end
                end
            end
            1: begin
                if (!stalled) m_iv = 0;
                if (!pre_iv && wb_q.size() == 0 && !m_wb_now) nst = 2;
            end
            default: begin
                m_tgrp = ~m_tgrp;
                m_last = N - 1;
                nst    = 0;
                if (!stalled) m_iv = 0;
            end
        endcase

        for (int i = 0; i < N; i++) begin
            if (m_st == 2) m_cnt[i] = 0;
            else if (block_valid && block_cycles != 0 && int'(block_tid) == i) m_cnt[i] = int'(block_cycles);
            else if (m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end

        if (!stalled) ne++;
        if (issued) begin
            w.tid   = m_tid;
            w.stamp = ne;
            wb_q.push_back(w);
        end
        m_st   = nst;
        e.iv   = m_iv;
        e.tid  = m_tid;
        e.tgrp = m_tgrp;
        exp_q.push_back(e);

        @(posedge clk);
        #1;

        e    = exp_q.pop_front();
        etid = B'(e.tid);
        n_tests++;
        if (issue_valid !== e.iv) begin
            n_fail++;
            $display("FAIL %s issue_valid got %b want %b", tag, issue_valid, e.iv);
        end
        n_tests++;
        if (tid_read !== etid) begin
            n_fail++;
            $display("FAIL %s tid_read got %0d want %0d", tag, tid_read, etid);
        end
        n_tests++;
        if (tgrp !== e.tgrp || grp_switch_ack !== e.ack) begin
            n_fail++;
            $display("FAIL %s tgrp/ack got %b/%b want %b/%b", tag, tgrp, grp_switch_ack, e.tgrp, e.ack);
        end

        // Writeback: frozen on a stalled edge, otherwise due exactly LAT
        // unstalled edges after issue.
        if (!stalled) begin
            if (wb_q.size() > 0 && ne - wb_q[0].stamp >= LAT) begin
                w        = wb_q.pop_front();
                m_wb_now = 1;
                m_wb_tid = w.tid;
                if (ne - w.stamp != LAT) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s wb latency got %0d want %0d", tag, ne - w.stamp, LAT);
                end
            end else begin
                m_wb_now = 0;
            end
        end
        n_tests++;
        if (wb_valid !== m_wb_now || (m_wb_now && tid_write !== B'(m_wb_tid))) begin
            n_fail++;
            $display("FAIL %s writeback got %b/%0d want %b/%0d", tag, wb_valid, tid_write, m_wb_now, m_wb_tid);
        end
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_tests++;
        if (issue_valid !== 1'b0 || tid_read !== '0 || tgrp !== 1'b0 ||
            wb_valid !== 1'b0 || tid_write !== '0 || grp_switch_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values got iv=%b tr=%0d tg=%b wv=%b tw=%0d ack=%b want all 0",
                     issue_valid, tid_read, tgrp, wb_valid, tid_write, grp_switch_ack);
        end
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if (issue_valid !== 1'b0 || wb_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold got iv=%b wv=%b want 0/0", issue_valid, wb_valid);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_round_robin();
        thread_active = 8'hFF;
        for (int i = 0; i <= N; i++) begin
            step("rr_all");
            n_tests++;
            if (issue_valid !== 1'b1 || tid_read !== B'(i % N)) begin
                n_fail++;
                $display("FAIL rr_all_seq got %b/%0d want 1/%0d", issue_valid, tid_read, i % N);
            end
        end
        repeat (LAT + 1) step("rr_all_wb");

        thread_active = 8'b0010_0100;
        repeat (8) step("rr_2_5");

        thread_active = 8'b0000_1000;
        for (int i = 0; i < 4; i++) begin
            step("rr_lone");
            n_tests++;
            if (tid_read !== 3'd3 || issue_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_lone got %b/%0d want 1/3", issue_valid, tid_read);
            end
        end

        thread_active = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step("rr_none");
            n_tests++;
            if (issue_valid !== 1'b0 || tid_read !== 3'd3) begin
                n_fail++;
                $display("FAIL rr_none got %b/%0d want 0/3", issue_valid, tid_read);
            end
        end
        thread_active = 8'hFF;
        repeat (5) step("rr_resume");
    endtask

    task automatic test_block();
        bit found = 0;
        thread_active = 8'hFF;
        for (int i = 0; i < 16 && !found; i++) begin
            if (issue_valid === 1'b1 && tid_read === 3'd1) found = 1;
            else step("blk_seek");
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL blk_seek got tid %0d want 1 within 16 cycles", tid_read);
        end
        block_valid  = 1'b1;
        block_tid    = 3'd2;
        block_cycles = 4'd4;
        step("blk_same_cycle");
        block_valid = 1'b0;
        n_tests++;
        if (tid_read !== 3'd2) begin
            n_fail++;
            $display("FAIL blk_same_cycle got %0d want 2", tid_read);
        end
        repeat (12) step("blk_all");

        // Small set so the blocked thread is visibly skipped.
        thread_active = 8'b0000_0111;
        block_valid   = 1'b1;
        block_tid     = 3'd1;
        block_cycles  = 4'd5;
        step("blk_small_load");
        block_valid = 1'b0;
        repeat (8) step("blk_small");

        // Zero-length block has no effect.
        block_valid  = 1'b1;
        block_tid    = 3'd0;
        block_cycles = 4'd0;
        step("blk_zero");
        block_valid = 1'b0;
        repeat (3) step("blk_zero_after");

        // Reload while counting wins over decrement.
        block_valid  = 1'b1;
        block_tid    = 3'd2;
        block_cycles = 4'd3;
        step("blk_reload_a");
        block_cycles = 4'd6;
        step("blk_reload_b");
        block_valid = 1'b0;
        repeat (10) step("blk_reload");
    endtask

    task automatic test_stall();
        logic [B-1:0] held_r;
        thread_active = 8'hFF;
        repeat (3) step("stall_pre");
        held_r     = tid_read;
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("stall_on");
            n_tests++;
            if (tid_read !== held_r) begin
                n_fail++;
                $display("FAIL stall_freeze got %0d want %0d", tid_read, held_r);
            end
        end
        pipe_stall = 1'b0;
        step("stall_resume");
        n_tests++;
        if (tid_read !== B'((int'(held_r) + 1) % N)) begin
            n_fail++;
            $display("FAIL stall_resume got %0d want %0d", tid_read, (int'(held_r) + 1) % N);
        end
        repeat (LAT + 2) step("stall_post");
    endtask

    task automatic test_reset_in_drain();
        thread_active = 8'hFF;
        repeat (3) step("rd_pre");
        grp_switch_req = 1'b1;
        step("rd_req");
        grp_switch_req = 1'b0;
        step("rd_drain");
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (issue_valid !== 1'b0 || tid_read !== '0 || wb_valid !== 1'b0 ||
            tid_write !== '0 || tgrp !== 1'b0 || grp_switch_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_async got iv=%b tr=%0d wv=%b tw=%0d tg=%b ack=%b want all 0",
                     issue_valid, tid_read, wb_valid, tid_write, tgrp, grp_switch_ack);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if (grp_switch_ack !== 1'b0 || tgrp !== 1'b0) begin
                n_fail++;
                $display("FAIL rd_no_ack got ack=%b tgrp=%b want 0/0", grp_switch_ack, tgrp);
            end
        end
        rst = 1'b0;
        model_reset();
        step("rd_restart");
        n_tests++;
        if (issue_valid !== 1'b1 || tid_read !== 3'd0) begin
            n_fail++;
            $display("FAIL rd_restart got %b/%0d want 1/0", issue_valid, tid_read);
        end
        repeat (LAT + 2) step("rd_post");
    endtask

    task automatic test_group_switch();
        bit ack_seen = 0;
        thread_active = 8'hFF;
        repeat (3) step("gs_pre");
        block_valid  = 1'b1;
        block_tid    = 3'd5;
        block_cycles = 4'd15;
        step("gs_block");
        block_valid    = 1'b0;
        grp_switch_req = 1'b1;
        step("gs_req");
        n_tests++;
        if (issue_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL gs_issue_off got %b want 0", issue_valid);
        end
        thread_active = 8'b0010_0001;
        for (int i = 0; i < 20 && !ack_seen; i++) begin
            // Request held for one drain cycle; it must be ignored.
            grp_switch_req = (i == 0);
            step("gs_drain");
            if (grp_switch_ack === 1'b1) ack_seen = 1;
        end
        grp_switch_req = 1'b0;
        n_tests++;
        if (!ack_seen || tgrp !== 1'b1) begin
            n_fail++;
            $display("FAIL gs_ack got seen=%b tgrp=%b want 1/1", ack_seen, tgrp);
        end
        step("gs_first");
        n_tests++;
        if (issue_valid !== 1'b1 || tid_read !== 3'd0 || grp_switch_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL gs_first got %b/%0d ack=%b want 1/0 ack=0", issue_valid, tid_read, grp_switch_ack);
        end
        step("gs_second");
        n_tests++;
        if (tid_read !== 3'd5) begin
            n_fail++;
            $display("FAIL gs_unblocked got %0d want 5", tid_read);
        end
        repeat (LAT + 3) step("gs_post");
    endtask

    // ------------------------------------------------------------------
    // Sequencer and watchdog
    // ------------------------------------------------------------------
    initial begin
        thread_active  = 8'hFF;
        block_valid    = 1'b0;
        block_tid      = '0;
        block_cycles   = '0;
        pipe_stall     = 1'b0;
        grp_switch_req = 1'b0;
        model_reset();

        test_reset();
        test_round_robin();
        test_block();
        test_stall();
        test_reset_in_drain();
        test_group_switch();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
